spectrum_frame_reader: RTL
==========================

SPECTRUM_FRAME_READER -- requirements
Module: spectrum_frame_reader

Interface
REQ-001 SHALL have parameter NUM_BINS, default 16, bins per frame; power of two, 4..64.
REQ-002 SHALL have parameter DATA_W, default 8, bin magnitude width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports listed below.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  bin word present on in_data this cycle.
REQ-007 in_sof  input  1  qualified by in_valid; marks bin 0 of a frame.
REQ-008 in_data  input  DATA_W  bin magnitude from the spectrum core output stream.
REQ-009 rd_addr  input  log2(NUM_BINS)  bin index to read from committed frame.
REQ-010 rd_data  output  DATA_W  registered committed-frame magnitude at rd_addr.
REQ-011 frame_done  output  1  one-cycle pulse: new frame committed.
REQ-012 frame_err  output  1  one-cycle pulse: frame aborted by early in_sof.
REQ-013 busy  output  1  high while in CAPTURE.
REQ-014 frame_cnt  output  8  committed-frame count, wraps 255->0.
REQ-015 peak_bin  output  log2(NUM_BINS)  index of largest bin in committed frame.
REQ-016 peak_mag  output  DATA_W  magnitude of that bin.

Function
REQ-017 SHALL hold two NUM_BINS x DATA_W banks (ping-pong): one capture bank, one committed bank.
REQ-018 FSM states IDLE, CAPTURE; reset enters IDLE.
REQ-019 IDLE: in_valid & in_sof -> write in_data to capture bank index 0, bin counter=1, go CAPTURE; in_valid without in_sof ignored.
REQ-020 CAPTURE: in_valid & !in_sof -> write capture bank at bin counter, counter+1; in_valid low -> hold (gaps allowed, no timeout).
REQ-021 CAPTURE: write of index NUM_BINS-1 -> swap banks, commit peak, frame_cnt+1, go IDLE; frame_done high the following cycle only.
REQ-022 CAPTURE: in_valid & in_sof before final bin -> frame_err pulse next cycle, discard partial frame, restart at index 0 with current word, stay CAPTURE; committed bank, frame_cnt, peak unchanged.
REQ-023 Sof on the cycle immediately after a commit SHALL be accepted as a normal IDLE start (back-to-back frames, zero dead cycles).
REQ-024 rd_data SHALL equal committed[rd_addr] one cycle after rd_addr is presented; a swap takes effect for reads issued the cycle after the final-bin write.
REQ-025 frame_done and frame_err SHALL never assert in the same cycle.
REQ-026 busy SHALL equal (state==CAPTURE).

Reset
REQ-027 Reset SHALL clear both banks to 0, FSM to IDLE, bin counter 0, bank select 0.
REQ-028 Reset outputs: rd_data 0, frame_done 0, frame_err 0, busy 0, frame_cnt 0, peak_bin 0, peak_mag 0.
REQ-029 Reset mid-capture SHALL discard the partial frame with no frame_err pulse; reset has priority over all inputs.

Configuration
REQ-030 Macro FRAME_PEAK_EN: defined -> running max tracked during capture (strictly greater replaces, ties keep lowest index), committed to peak_bin/peak_mag at swap; aborted frames discard the running max.
REQ-031 FRAME_PEAK_EN undefined -> no comparator logic; peak_bin and peak_mag tied to 0.

Verification
REQ-032 Reset, sof on word 0, 16 words 10..25 contiguous -> frame_done one cycle after final word, frame_cnt=1, rd_addr=5 gives rd_data=15 next cycle, peak_bin=15, peak_mag=25 (with FRAME_PEAK_EN).
REQ-033 Sof + 7 words, then sof again + 16 words 0x80 -> frame_err single pulse at restart, then frame_done, all bins read 0x80, frame_cnt=1.
REQ-034 Frame with bins 3 and 9 both 0xFF, others 0x01 -> peak_bin=3, peak_mag=0xFF; without FRAME_PEAK_EN both read 0.
REQ-035 Two back-to-back frames (second sof cycle after first final word), in_valid toggling every other cycle in second -> two frame_done pulses, rd_data shows frame-1 values until second commit, then frame-2 values.
REQ-036 Assert rst after 10 bins of a frame -> busy=0, no frame_err, frame_cnt=0, all reads 0; non-sof words afterwards ignored until next sof.
REQ-037 256 complete frames -> frame_cnt wraps to 0 on the 256th frame_done.

Source files
------------

// File: rtl/spectrum_frame_reader.sv
// rtl/spectrum_frame_reader.sv - ping-pong spectrum frame capture with committed-frame read port
//
// Captures one NUM_BINS-word spectrum frame from the core output stream into the
// capture bank. When the final bin is written, it swaps that bank with the committed bank.
// The committed frame is read through a registered random-access port.
//
// Optional feature macro: FRAME_PEAK_EN
//   defined   -> running maximum tracked during capture and published at commit.
//   undefined -> no comparator; peak_bin / peak_mag tied to 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        bin word present on in_data
//   in_sof          with in_valid, marks bin 0 of a frame
//   in_data         bin magnitude
//   rd_addr         committed-frame bin index to read
//   rd_data         registered committed[rd_addr]
//   frame_done      one-cycle pulse after a frame commits
//   frame_err       one-cycle pulse after a partial frame is aborted by in_sof
//   busy            high while capturing
//   frame_cnt       committed-frame count, wraps 255->0
//   peak_bin        index of largest bin in committed frame
//   peak_mag        magnitude of that bin

module spectrum_frame_reader #(
   parameter int NUM_BINS = 16,
   parameter int DATA_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic                        in_sof,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        frame_done,
   output logic                        frame_err,
   output logic                        busy,
   output logic [7:0]                  frame_cnt,
   output logic [$clog2(NUM_BINS)-1:0] peak_bin,
   output logic [DATA_W-1:0]           peak_mag
);

   localparam int AW = $clog2(NUM_BINS);
   localparam logic [AW-1:0] LAST_BIN = AW'(NUM_BINS - 1);

   typedef enum logic {S_IDLE, S_CAPTURE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_bin_cnt;
   logic              r_sel;      // selects the committed bank; capture bank is the other one
   logic [DATA_W-1:0] r_bank0 [NUM_BINS];
   logic [DATA_W-1:0] r_bank1 [NUM_BINS];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_done;
   logic              r_err;
   logic [7:0]        r_frame_cnt;

   logic              w_wr_en;
   logic [AW-1:0]     w_wr_idx;
   logic              w_start;    // word written at index 0 (new or restarted frame)
   logic              w_commit;
   logic              w_abort;

   // ---------------- FSM next-state / control ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_bin_cnt;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && in_sof) begin
               w_wr_en     = 1'b1;
               w_wr_idx    = '0;
               w_start     = 1'b1;
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (in_valid) begin
               w_wr_en = 1'b1;
               if (in_sof) begin
                  // early sof: drop partial frame and restart with this word
                  w_wr_idx = '0;
                  w_start  = 1'b1;
                  w_abort  = 1'b1;
               end else if (r_bin_cnt == LAST_BIN) begin
                  w_commit    = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ---------------- banks, counters, pulses ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BINS; i++) begin
            r_bank0[i] <= '0;
            r_bank1[i] <= '0;
         end
         r_bin_cnt   <= '0;
         r_sel       <= 1'b0;
         r_rd_data   <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         // read uses the pre-edge bank select, so a swap is seen by reads issued next cycle
         r_rd_data <= r_sel ? r_bank1[rd_addr] : r_bank0[rd_addr];
         r_done    <= w_commit;
         r_err     <= w_abort;
         if (w_wr_en) begin
            if (r_sel) r_bank0[w_wr_idx] <= in_data;
            else       r_bank1[w_wr_idx] <= in_data;
         end
         // counter wraps LAST_BIN -> 0 on the commit write
         if (w_start)      r_bin_cnt <= AW'(1);
         else if (w_wr_en) r_bin_cnt <= r_bin_cnt + AW'(1);
         if (w_commit) begin
            r_sel       <= ~r_sel;
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign rd_data    = r_rd_data;
   assign frame_done = r_done;
   assign frame_err  = r_err;
   assign busy       = (r_state == S_CAPTURE);
   assign frame_cnt  = r_frame_cnt;

   // ---------------- optional peak tracking ----------------
`ifdef FRAME_PEAK_EN
   logic [DATA_W-1:0] r_run_mag;
   logic [AW-1:0]     r_run_bin;
   logic [DATA_W-1:0] r_peak_mag;
   logic [AW-1:0]     r_peak_bin;
   logic              w_gt;

   // strictly greater replaces, so ties keep the lowest index
   assign w_gt = (in_data > r_run_mag);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run_mag  <= '0;
         r_run_bin  <= '0;
         r_peak_mag <= '0;
         r_peak_bin <= '0;
      end else begin
         if (w_start) begin
            r_run_mag <= in_data;
            r_run_bin <= '0;
         end else if (w_wr_en && w_gt) begin
            r_run_mag <= in_data;
            r_run_bin <= w_wr_idx;
         end
         // commit includes the final word, which is not yet in the running max
         if (w_commit) begin
            r_peak_mag <= w_gt ? in_data : r_run_mag;
            r_peak_bin <= w_gt ? w_wr_idx : r_run_bin;
         end
      end
   end

   assign peak_bin = r_peak_bin;
   assign peak_mag = r_peak_mag;
`else
   assign peak_bin = '0;
   assign peak_mag = '0;
`endif

endmodule
